// File: rtl/alu_exec_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops plus an iterative
// signed mult/div sequencer that writes HI/LO and reports busy/done.
module alu_exec_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 alucontrol,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  input  logic                       start,
  output logic [WIDTH-1:0]           result,
  output logic                       zero,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           hi,
  output logic [WIDTH-1:0]           lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_PASS = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_MULT = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic              op_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]  acc, q, opb;

  logic              launch;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  // Single-cycle ALU result and zero flag
  always_comb begin
    result = '0;
    case (alucontrol)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_PASS: result = a;
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

  // Operand magnitudes, per-step arithmetic and final sign correction
  always_comb begin
    launch    = start && (state == IDLE) && ((alucontrol == OP_MULT) || (alucontrol == OP_DIV));
    abs_a     = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    abs_b     = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, opb} : '0);
    div_shift = {acc, q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_fix  = neg_q ? ((2*WIDTH)'(0) - {acc, q}) : {acc, q};
    quo_fix   = div_zero ? '1 : (neg_q ? (WIDTH'(0) - q) : q);
    rem_fix   = neg_r ? (WIDTH'(0) - acc) : acc;
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Sequencer next-state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, HI/LO write and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      q        <= '0;
      opb      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == FIX);
      case (state)
        IDLE: if (launch) begin
          op_div   <= (alucontrol == OP_DIV);
          neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r    <= a[WIDTH-1];
          div_zero <= (b == '0);
          acc      <= '0;
          q        <= abs_a;
          opb      <= abs_b;
          cnt      <= CW'(WIDTH);
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (op_div) begin
            // restoring step: keep the subtraction only when it does not borrow
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_shift[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            // shift-add step: multiplier drains out of q as product bits enter
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_muldiv.sv
// Scoreboard bench for alu_exec_muldiv: directed and random combinational
// checks plus mult/div launches compared against a plain-arithmetic model.
module tb_alu_exec_muldiv;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    alucontrol;
  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic          start;
  logic [W-1:0]  result;
  logic          zero, busy, done;
  logic [W-1:0]  hi, lo;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];

  alu_exec_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .alucontrol(alucontrol), .a(a), .b(b),
    .shamt(shamt), .start(start), .result(result), .zero(zero),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference ALU result
  function automatic logic [W-1:0] ref_alu(input logic [3:0] code, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [4:0] s);
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (code)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b0011: return x;
      4'b1000: return y << s;
      4'b1001: return y >> s;
      default: return 32'd0;
    endcase
  endfunction

  // Reference {hi,lo} for mult / div
  function automatic logic [63:0] ref_muldiv(input logic is_div, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint sx, sy, p, qt, rm;
    logic [63:0] pv, qv, rv;
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    if (!is_div) begin
      p  = sx * sy;
      pv = p;
      return pv;
    end
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    qt = sx / sy;
    rm = sx % sy;
    qv = qt;
    rv = rm;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Monitor: scores every done pulse and the HI/LO values written after it
  initial begin
    int busy_run = 0;
    logic pending = 1'b0;
    logic [63:0] expv = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_run = 0;
        pending  = 1'b0;
      end else begin
        if (busy) busy_run++;
        if (pending) begin
          check("hilo", {hi, lo}, expv);
          check("done_width", {63'd0, done}, 64'd0);
          check("busy_after", {63'd0, busy}, 64'd0);
          pending = 1'b0;
        end
        if (done) begin
          done_seen++;
          check("busy_len", 64'(busy_run), 64'(W + 1));
          busy_run = 0;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done with empty queue expected none");
          end else begin
            expv    = exp_q.pop_front();
            pending = 1'b1;
          end
        end
      end
    end
  end

  task automatic comb_check(input logic [3:0] code, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [4:0] s);
    logic [W-1:0] r;
    @(negedge clk);
    alucontrol = code; a = x; b = y; shamt = s; start = 1'b0;
    #1;
    r = ref_alu(code, x, y, s);
    check("result", {32'd0, result}, {32'd0, r});
    check("zero", {63'd0, zero}, {63'd0, (r == 0)});
  endtask

  task automatic launch(input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    alucontrol = code; a = x; b = y; start = 1'b1;
    exp_q.push_back(ref_muldiv(code == 4'b1011, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
    int d0;
    d0 = done_seen;
    launch(code, x, y);
    wait_idle();
    check("done_count", 64'(done_seen - d0), 64'd1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return 32'(int'($urandom_range(0, 40)) - 20);
      1: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      2: return ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      default: return $urandom;
    endcase
  endfunction

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int d0;
    logic [63:0] hl;
    reset = 1'b1; start = 1'b0; alucontrol = 4'b0000; a = '0; b = '0; shamt = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    comb_check(4'b0010, 32'd5, 32'd7, 5'd0);
    comb_check(4'b0110, 32'd5, 32'd7, 5'd0);
    comb_check(4'b0111, 32'd5, 32'd7, 5'd0);
    comb_check(4'b0000, 32'd5, 32'd7, 5'd0);
    comb_check(4'b0001, 32'd5, 32'd7, 5'd0);
    comb_check(4'b0110, 32'd3, 32'd3, 5'd0);
    comb_check(4'b1000, 32'd0, 32'd1, 5'd31);
    comb_check(4'b1001, 32'd0, 32'h8000_0000, 5'd31);
    comb_check(4'b0011, 32'h1234_5678, 32'd9, 5'd0);
    comb_check(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0);
    comb_check(4'b1010, 32'd6, 32'd7, 5'd0);
    comb_check(4'b1111, 32'd6, 32'd7, 5'd0);
    for (int i = 0; i < 40; i++)
      comb_check(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));

    run_op(4'b1010, 32'hFFFF_FFFD, 32'd7);
    run_op(4'b1011, 32'hFFFF_FFF9, 32'd2);
    run_op(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'b1011, 32'd9, 32'd0);

    // start with a non-mult/div code must not touch the sequencer
    hl = {hi, lo};
    @(negedge clk);
    alucontrol = 4'b0010; a = 32'd1; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("nonmd_busy", {63'd0, busy}, 64'd0);
    check("nonmd_hilo", {hi, lo}, hl);

    // start while busy is ignored
    d0 = done_seen;
    launch(4'b1010, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    alucontrol = 4'b1011; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check("ignored_done_count", 64'(done_seen - d0), 64'd1);
    check("ignored_hilo", {hi, lo}, 64'd42);

    // asynchronous reset mid-operation aborts without trace
    run_op(4'b1011, 32'd9, 32'd0);
    d0 = done_seen;
    launch(4'b1010, 32'd6, 32'd7);
    repeat (13) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    check("abort_hilo_hold", {hi, lo}, 64'd0);
    run_op(4'b1011, 32'd100, 32'd3);
    check("post_reset_div", {hi, lo}, {32'd1, 32'd33});

    // random mult/div
    for (int i = 0; i < 24; i++)
      run_op(($urandom_range(0, 1) != 0) ? 4'b1011 : 4'b1010, rnd_operand(), rnd_operand());

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_muldiv.md
Name: alu_exec_muldiv

Overview:
- Execute-stage ALU that consumes the 4-bit alucontrol code from the ALU decoder.
- Single-cycle ops are combinational.
- mult/div (codes 1010/1011) run on an iterative multi-cycle sequencer that writes HI/LO registers.
- The sequencer drives a busy signal so the pipeline hazard unit can stall the pipeline until the HI/LO result is ready.

Parameters:
- WIDTH, 32, datapath width. mult/div iterate WIDTH cycles. shamt width is $clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  reset. One clock; reset is asynchronous and active-high.
- alucontrol  input  4  operation code from the ALU decoder
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt or immediate)
- shamt  input  $clog2(WIDTH)  shift amount
- start  input  1  EX-stage instruction valid; qualifies mult/div launch
- result  output  WIDTH  combinational ALU result
- zero  output  1  result == 0
- busy  output  1  mult/div in progress; pipeline must stall
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Combinational result by code:
  - 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b (wrap, no overflow trap)
  - 0111 signed a<b ? 1 : 0; 0011 a (pass, jal)
  - 1000 b<<shamt; 1001 b>>shamt (logical)
  - 1010, 1011 and any other code: result=0
- zero = (result==0) for every code.
- Sequencer states IDLE, RUN, FIX:
  - IDLE->RUN at a rising edge with start=1 and alucontrol in {1010,1011}. This edge latches the op, |a|, |b|, sign flags, and loads the iteration counter to WIDTH.
  - RUN: one shift-add step (mult) or one restoring-subtract step (div) per cycle; counter decrements. RUN->FIX when the counter reaches 0 (exactly WIDTH RUN cycles).
  - FIX: apply sign correction, write hi/lo, assert done for this one cycle, return to IDLE.
- Latency: launch at edge 0 -> busy=1 from after edge 0 through the FIX cycle (WIDTH+1 cycles). hi/lo are written at edge WIDTH+1, together with done falling and busy falling.
- mult: signed {hi,lo} = a*b, 2*WIDTH-bit product.
- div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - b==0: lo = all ones, hi = a. Same latency, no error flag.
  - a = -2^(WIDTH-1), b = -1: lo = 0x80000000, hi = 0.
- start while busy: ignored. Operands are not re-latched and the running op is undisturbed.
- start with a non-mult/div code: no sequencer effect; hi/lo unchanged.
- hi/lo change only in FIX (or on reset).
- reset asserted, at any time including mid-operation: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 immediately. The aborted operation leaves no trace.
- The datapath holds no other state; result and zero are purely combinational.

Test Plan:
- Combinational sweep: a=5, b=7 with codes 0010/0110/0111/0000/0001 -> result=12/0xFFFFFFFE/1/5/7. a=b=3 code 0110 -> result=0, zero=1. b=1, shamt=31, code 1000 -> 0x80000000.
- mult a=-3 (0xFFFFFFFD), b=7, start for 1 cycle -> busy high 33 cycles. done pulses once. hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 33 cycles. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- div a=9, b=0 -> lo=0xFFFFFFFF, hi=9, done at cycle 33. busy never extends.
- mult 6*7 launched; on cycle 10 issue start with div 100/3 -> ignored. Final hi=0, lo=42, exactly one done pulse.
- Launch mult 6*7, assert reset asynchronously (mid-cycle) on cycle 15 -> busy/done/hi/lo go 0 immediately. After release, a fresh div 100/3 -> lo=33, hi=1.
